// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Main control state machine for the multicycle ARM datapath. Sequences
//   fetch, decode, execute, memory and writeback steps from op/funct and
//   drives the datapath select lines plus alu_op for the ALU decoder.
//   Outputs are decoded from the registered state. The exception is FETCH
//   with MEM_WAIT_EN defined, where ir_write/next_pc also depend on mem_ready.
//
//   Optional feature macro: MEM_WAIT_EN
//     When defined, FETCH, MEMRD and MEMWR hold until mem_ready = 1.
//     When undefined, mem_ready is ignored and every state lasts one cycle.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   op         in   [1:0] instr[27:26]
//   funct      in   [5:0] instr[25:20]; [5] = I, [0] = S/L
//   mem_ready  in   memory access complete (MEM_WAIT_EN only)
//   ir_write   out  instruction register load enable
//   next_pc    out  PC update request
//   reg_w      out  register file write request (ungated by condition)
//   mem_w      out  data memory write request (ungated by condition)
//   branch     out  branch request (ungated by condition)
//   adr_src    out  memory address select: 0 = PC, 1 = ALU result
//   alu_src_a  out  [1:0] 00 = register A, 01 = PC
//   alu_src_b  out  [1:0] 00 = register B, 01 = ext. immediate, 10 = 4
//   result_src out  [1:0] 00 = ALU out reg, 01 = read data, 10 = ALU result
//   alu_op     out  1 = decode cmd, 0 = force ADD
//   state_o    out  [3:0] current state code

module multicycle_main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    state_t state;
    state_t state_next;

    // Memory handshake: constant 1 when waiting is compiled out.
    logic mem_go;
`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go           = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    if (mem_go) state_next = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   state_next = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_next = MEMADR;
                    2'b10:   state_next = BRANCH;
                    default: state_next = UNKNOWN;
                endcase
            end
            MEMADR:   state_next = funct[0] ? MEMRD : MEMWR;
            MEMRD:    if (mem_go) state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWR:    if (mem_go) state_next = FETCH;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = FETCH;
            UNKNOWN:  state_next = FETCH;
            default:  state_next = FETCH;  // codes 11..15 recover to FETCH
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 1'b0;
        case (state)
            FETCH: begin
                // With waiting enabled the fetch strobes fire only on the
                // cycle the instruction word is actually available.
                ir_write   = mem_go;
                next_pc    = mem_go;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            MEMADR: begin
                alu_src_b  = 2'b01;
            end
            MEMRD: begin
                adr_src    = 1'b1;
            end
            MEMWB: begin
                reg_w      = 1'b1;
                result_src = 2'b01;
            end
            MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
            end
            EXECUTER: begin
                alu_op     = 1'b1;
            end
            EXECUTEI: begin
                alu_src_b  = 2'b01;
                alu_op     = 1'b1;
            end
            ALUWB: begin
                reg_w      = 1'b1;
            end
            BRANCH: begin
                branch     = 1'b1;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
            end
            default: ;
        endcase
        // Strobes are suppressed while reset is held; selects keep FETCH values.
        if (reset) begin
            ir_write = 1'b0;
            next_pc  = 1'b0;
            reg_w    = 1'b0;
            mem_w    = 1'b0;
            branch   = 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
module tb_multicycle_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ir_write, next_pc, reg_w, mem_w, branch, adr_src, alu_op;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [12:0] outs;
    } exp_t;

    exp_t exp_q[$];
    logic mr_q[$];

    multicycle_main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .branch     (branch),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Packed order: ir_write next_pc reg_w mem_w branch adr_src a[2] b[2] rs[2] alu_op
    function automatic logic [12:0] model_out(input logic [3:0] st, input logic mr);
        logic f;
`ifdef MEM_WAIT_EN
        f = mr;
`else
        f = 1'b1;
        if (mr) f = 1'b1;
`endif
        case (st)
            4'd0:    model_out = {f, f, 11'b000_0_01_10_10_0};
            4'd1:    model_out = 13'b0_0_000_0_01_10_10_0;
            4'd2:    model_out = 13'b0_0_000_0_00_01_00_0;
            4'd3:    model_out = 13'b0_0_000_1_00_00_00_0;
            4'd4:    model_out = 13'b0_0_100_0_00_00_01_0;
            4'd5:    model_out = 13'b0_0_010_1_00_00_00_0;
            4'd6:    model_out = 13'b0_0_000_0_00_00_00_1;
            4'd7:    model_out = 13'b0_0_000_0_00_01_00_1;
            4'd8:    model_out = 13'b0_0_100_0_00_00_00_0;
            4'd9:    model_out = 13'b0_0_001_0_00_01_10_0;
            default: model_out = 13'b0;
        endcase
    endfunction

    function automatic logic [12:0] observed();
        return {ir_write, next_pc, reg_w, mem_w, branch, adr_src,
                alu_src_a, alu_src_b, result_src, alu_op};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic plan(input logic [3:0] st, input logic mr);
        exp_t e;
        e.st   = st;
        e.outs = model_out(st, mr);
        exp_q.push_back(e);
        mr_q.push_back(mr);
    endtask

    // op/funct are driven correctly only in DECODE/MEMADR; elsewhere they
    // carry noise that must not affect the sequence.
    task automatic play(input string name, input logic [1:0] i_op, input logic [5:0] i_funct);
        exp_t e;
        int   step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = mr_q.pop_front();
            if (e.st == 4'd1 || e.st == 4'd2) begin
                op    = i_op;
                funct = i_funct;
            end else begin
                op    = 2'($urandom);
                funct = 6'($urandom);
            end
            #1;
            check($sformatf("%s_state%0d", name, step), {9'b0, state_o}, {9'b0, e.st});
            check($sformatf("%s_outs%0d", name, step), observed(), e.outs);
            step++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        op        = 2'b00;
        funct     = 6'b0;
        mem_ready = 1'b1;
        #2;
        check("rst_state", {9'b0, state_o}, 13'd0);
        check("rst_outs", observed(), 13'b0_0_000_0_01_10_10_0);
        @(posedge clk); #1;
        check("rst_hold_state", {9'b0, state_o}, 13'd0);
        check("rst_hold_outs", observed(), 13'b0_0_000_0_01_10_10_0);
        reset = 1'b0;

        // LDR interrupted by reset in MEMRD
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd2, 1'b1);
        play("ldr_abort", 2'b01, 6'b011001);
        check("pre_abort_state", {9'b0, state_o}, 13'd3);
        #2 reset = 1'b1;
        #1;
        check("abort_state", {9'b0, state_o}, 13'd0);
        check("abort_outs", observed(), 13'b0_0_000_0_01_10_10_0);
        @(posedge clk); #1;
        check("abort_hold_outs", observed(), 13'b0_0_000_0_01_10_10_0);
        #2 reset = 1'b0;

        // Immediate data-processing after reset release
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd7, 1'b1); plan(4'd8, 1'b1);
        play("dpi", 2'b00, 6'b101001);

        // LDR
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd2, 1'b1); plan(4'd3, 1'b1); plan(4'd4, 1'b1);
        play("ldr", 2'b01, 6'b011001);

        // STR
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd2, 1'b1); plan(4'd5, 1'b1);
        play("str", 2'b01, 6'b011000);

        // Register data-processing
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd6, 1'b1); plan(4'd8, 1'b1);
        play("dpr", 2'b00, 6'b001000);

        // Branch
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd9, 1'b1);
        play("b", 2'b10, 6'b100000);

        // Undefined
        plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd10, 1'b1);
        play("undef", 2'b11, 6'b111111);

`ifdef MEM_WAIT_EN
        // STR with a one-cycle fetch stall and three MEMWR wait cycles
        plan(4'd0, 1'b0); plan(4'd0, 1'b1); plan(4'd1, 1'b1); plan(4'd2, 1'b1);
        plan(4'd5, 1'b0); plan(4'd5, 1'b0); plan(4'd5, 1'b0); plan(4'd5, 1'b1);
        play("str_wait", 2'b01, 6'b000000);
`endif

        plan(4'd0, 1'b1);
        play("final", 2'b00, 6'b000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
